// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the RV32I pipeline front end: datapath width,
// the canonical NOP encoding (ADDI x0,x0,0), the default boot PC and the
// IF/ID pipeline-register record.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     instr;
    } ifid_t;

endpackage

// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg
// IF/ID pipeline register between fetch and decode.
// Priority on each rising edge: rst > flush > hold > load.
//   rst   : valid=0, instr=NOP, pc=RESET_PC, pc_plus4=RESET_PC+4
//   flush : valid=0, instr=NOP, pc/pc_plus4 keep their values
//   hold  : everything keeps its value
//   load  : capture d_pc / d_pc_plus4 / d_instr with valid=1
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hold, flush       hazard stall, redirect flush
//   d_pc, d_pc_plus4  PC and link address of the word being fetched
//   d_instr           fetched instruction word
//   q_*               registered IF/ID contents
module ifid_pipe_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_pc_plus4,
    input  logic [31:0]     d_instr,
    output logic            q_valid,
    output logic [XLEN-1:0] q_pc,
    output logic [XLEN-1:0] q_pc_plus4,
    output logic [31:0]     q_instr
);

    localparam logic [XLEN-1:0] RESET_PC_PLUS4 = RESET_PC + XLEN'(4);

    ifid_t r_ifid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid.valid    <= 1'b0;
            r_ifid.pc       <= RESET_PC;
            r_ifid.pc_plus4 <= RESET_PC_PLUS4;
            r_ifid.instr    <= NOP_INSTR;
        end else if (flush) begin
            // Bubble: the PC fields are left alone because decode ignores
            // them while valid is low.
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= NOP_INSTR;
        end else if (!hold) begin
            r_ifid.valid    <= 1'b1;
            r_ifid.pc       <= d_pc;
            r_ifid.pc_plus4 <= d_pc_plus4;
            r_ifid.instr    <= d_instr;
        end
    end

    assign q_valid    = r_ifid.valid;
    assign q_pc       = r_ifid.pc;
    assign q_pc_plus4 = r_ifid.pc_plus4;
    assign q_instr    = r_ifid.instr;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
// Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC and
// the next-PC selection, drives the instruction-memory address straight
// from the PC register, and feeds the IF/ID register (ifid_pipe_reg).
// Per-edge priority: rst > redirect_valid > stall > sequential fetch.
// A redirect costs exactly one bubble and overrides a concurrent stall.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   stall                        hazard hold of PC and IF/ID
//   redirect_valid, redirect_pc  EX-stage control-flow change and target
//   imem_addr, imem_rdata        instruction-memory address / returned word
//   ifid_valid, ifid_pc,
//   ifid_pc_plus4, ifid_instr    IF/ID register contents for decode
//   misalign_err                 sticky: some redirect target had bits[1:0]!=0
//   fetch_count                  (FETCH_PERF_CNT_EN only) valid-fetch count
// Build option: define FETCH_PERF_CNT_EN to add the fetch_count output.
module if_fetch_stage #(
    parameter int                  XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]     RESET_PC = riscv_pkg::DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [31:0]     ifid_instr,
    output logic            misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count
`endif
);

    import riscv_pkg::*;

    logic [XLEN-1:0] r_pc;
    logic            r_misalign_err;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_target;

    // Wraps modulo 2^XLEN with no flag.
    assign w_pc_plus4        = r_pc + XLEN'(4);
    // The target is forced to a word boundary; the low bits only feed
    // the sticky error flag.
    assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
            if (redirect_pc[1:0] != 2'b00) begin
                r_misalign_err <= 1'b1;
            end
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    ifid_pipe_reg #(
        .RESET_PC (RESET_PC)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .flush      (redirect_valid),
        .d_pc       (r_pc),
        .d_pc_plus4 (w_pc_plus4),
        .d_instr    (imem_rdata),
        .q_valid    (ifid_valid),
        .q_pc       (ifid_pc),
        .q_pc_plus4 (ifid_pc_plus4),
        .q_instr    (ifid_instr)
    );

    assign imem_addr    = r_pc;
    assign misalign_err = r_misalign_err;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    // Counts exactly the edges on which IF/ID loads a real instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
        end else if (!redirect_valid && !stall) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Holds the program counter and drives the instruction-memory address.
- Captures the fetched word, PC and PC+4 into the IF/ID pipeline register consumed by decode.
- Applies hazard-unit stalls and EX-stage redirects (taken branch/jump) with a one-bubble flush.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard-unit hold; freezes PC and IF/ID contents
- redirect_valid  input  1  EX-stage control-flow change this cycle
- redirect_pc  input  XLEN  target PC when redirect_valid=1
- imem_addr  output  XLEN  instruction-memory word address (= current PC)
- imem_rdata  input  32  instruction word returned combinationally for imem_addr
- ifid_valid  output  1  IF/ID holds a real instruction
- ifid_pc  output  XLEN  PC of the instruction in IF/ID
- ifid_pc_plus4  output  XLEN  ifid_pc + 4, used for JAL/JALR link
- ifid_instr  output  32  instruction word in IF/ID
- misalign_err  output  1  sticky flag: a redirect target had non-zero bits [1:0]

Behaviour:
- Reset (rst=1 at clock edge, dominates all other inputs):
  - pc <= RESET_PC; ifid_valid <= 0; ifid_pc <= RESET_PC; ifid_pc_plus4 <= RESET_PC+4.
  - ifid_instr <= NOP (32'h0000_0013); misalign_err <= 0.
- imem_addr is driven directly from the PC register (no combinational path from inputs).
- Per-edge priority, rst > redirect_valid > stall > normal:
  - Redirect:
    - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
    - IF/ID flushed: ifid_valid <= 0, ifid_instr <= NOP; ifid_pc and ifid_pc_plus4 hold.
    - Applies even when stall=1 (the redirect overrides the stall).
  - Redirect misalignment: if redirect_pc[1:0] != 0, misalign_err <= 1. It stays 1 until rst.
  - Stall (no redirect): pc, all ifid_* outputs and misalign_err hold their values.
  - Normal:
    - ifid_pc <= pc; ifid_pc_plus4 <= pc+4; ifid_instr <= imem_rdata; ifid_valid <= 1.
    - pc <= pc+4.
- Latency: an instruction at PC p appears in IF/ID one edge after imem_addr=p, given no stall or redirect.
- Redirect penalty: exactly one bubble. The target appears in IF/ID two edges after redirect_valid is sampled.
- Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.
- redirect_pc is ignored when redirect_valid=0.
- The first normal edge after reset release loads the RESET_PC instruction. No extra boot bubble.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [31:0], reset 0.
  - Increments by 1 on every edge where IF/ID loads a valid instruction (normal case only), wrapping at 2^32.
  - Holds on stall, redirect and reset release.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg:
  - XLEN.
  - NOP_INSTR (32'h0000_0013).
  - DEFAULT_RESET_PC.
  - typedef struct ifid_t {valid, pc, pc_plus4, instr}.
- Sub-module ifid_pipe_reg holds the IF/ID register. It takes rst, a hold input (stall) and a flush input (redirect), and its reset/flush value is NOP with valid=0.
- PC register and next-PC mux stay in if_fetch_stage.

Test Plan:
- Reset: rst=1 for 2 edges, imem_rdata=32'h0050_0093 → imem_addr=0, ifid_valid=0, ifid_instr=32'h13, misalign_err=0. First edge after release → ifid_pc=0, ifid_instr=32'h0050_0093, ifid_valid=1, imem_addr=4.
- Sequential: 3 normal edges from reset release → imem_addr=32'h0C, ifid_pc=32'h08, ifid_pc_plus4=32'h0C, ifid_valid=1.
- Stall: stall=1 for 2 edges with imem_addr=32'h08 → imem_addr and all ifid_* unchanged. On release, the next edge gives ifid_pc=32'h08, imem_addr=32'h0C.
- Redirect over stall: stall=1, redirect_valid=1, redirect_pc=32'h100 →
  - next edge: imem_addr=32'h100, ifid_valid=0, ifid_instr=32'h13;
  - following normal edge: ifid_pc=32'h100, ifid_valid=1.
- Misaligned target plus wrap-around:
  - redirect_pc=32'h102 → imem_addr=32'h100, misalign_err=1, and it stays 1 across 5 further edges.
  - redirect_pc=32'hFFFF_FFFC → two edges later ifid_pc=32'hFFFF_FFFC, ifid_pc_plus4=0, imem_addr=0.
- Reset mid-operation: rst=1 together with redirect_valid=1, redirect_pc=32'h200 → all outputs at reset values (imem_addr=RESET_PC, misalign_err=0). With FETCH_PERF_CNT_EN defined, fetch_count=0.
